mem_bus_arbiter: RTL and testbench

- Parametrised N-master to 1-slave memory bus arbiter for the core's memory interface.
- Generalises the core's separate instruction and data buses onto one shared external port, so the core, a DMA channel, a debug port, etc. can share one memory.
- Selectable arbitration: fixed priority or round robin.
- Registers each winning request and holds it stable until the slave acknowledges it.

---
 rtl/mem_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// N-master to 1-slave memory bus arbiter with fixed-priority or round-robin selection.
// The winning request is latched onto the slave port and held until the slave acknowledges it.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 16,
  parameter int ROUND_ROBIN = 1,
  localparam int BW = DATA_WIDTH / 8,
  localparam int GW = $clog2(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out,
  input  logic [NUM_MASTERS-1:0]        m_wr_en,
  input  logic [NUM_MASTERS*BW-1:0]     m_bytesel,
  input  logic [NUM_MASTERS-1:0]        m_io,
  input  logic [NUM_MASTERS-1:0]        m_access,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [DATA_WIDTH-1:0]         m_data_in,
  output logic [ADDR_WIDTH-1:0]         s_addr,
  output logic [DATA_WIDTH-1:0]         s_data_out,
  output logic                          s_wr_en,
  output logic [BW-1:0]                 s_bytesel,
  output logic                          s_io,
  output logic                          s_access,
  input  logic                          s_ack,
  input  logic [DATA_WIDTH-1:0]         s_data_in,
  output logic [GW-1:0]                 grant,
  output logic                          busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_s_addr;
  logic [DATA_WIDTH-1:0] r_s_data_out;
  logic                  r_s_wr_en;
  logic [BW-1:0]         r_s_bytesel;
  logic                  r_s_io;
  logic [GW-1:0]         r_grant;
  logic [GW-1:0]         w_win;
  logic [GW-1:0]         w_idx;
  logic                  w_found;
  logic                  w_any;
  logic [NUM_MASTERS-1:0] w_ack;

  assign w_any = |m_access;

  // Round robin searches upward from the slot after the last grant, wrapping modulo NUM_MASTERS.
  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (ROUND_ROBIN != 0) begin
        w_idx = GW'((int'(r_grant) + 1 + k) % NUM_MASTERS);
      end else begin
        w_idx = GW'(k);
      end
      if (!w_found && m_access[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next_state = BUSY;
      BUSY:    if (s_ack) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_addr     <= '0;
      r_s_data_out <= '0;
      r_s_wr_en    <= 1'b0;
      r_s_bytesel  <= '0;
      r_s_io       <= 1'b0;
      r_grant      <= GW'(NUM_MASTERS - 1);
    end else if (r_state == IDLE && w_any) begin
      r_s_addr     <= m_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
      r_s_data_out <= m_data_out[w_win*DATA_WIDTH +: DATA_WIDTH];
      r_s_wr_en    <= m_wr_en[w_win];
      r_s_bytesel  <= m_bytesel[w_win*BW +: BW];
      r_s_io       <= m_io[w_win];
      r_grant      <= w_win;
    end
  end

  // The slave ack is steered straight back to the granted master in the same cycle.
  always_comb begin
    w_ack = '0;
    if (r_state == BUSY) begin
      w_ack[r_grant] = s_ack;
    end
  end

  assign m_ack      = w_ack;
  assign m_data_in  = s_data_in;
  assign s_addr     = r_s_addr;
  assign s_data_out = r_s_data_out;
  assign s_wr_en    = r_s_wr_en;
  assign s_bytesel  = r_s_bytesel;
  assign s_io       = r_s_io;
  assign s_access   = (r_state == BUSY);
  assign busy       = (r_state == BUSY);
  assign grant      = r_grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a round-robin and a fixed-priority instance (3 masters each)
// share the same master/slave stimulus; a per-cycle vector table plus hand-written sequences.
module tb_mem_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 19;
  localparam int DW = 16;
  localparam int BW = DW / 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_data_out = '0;
  logic [N-1:0]    m_wr_en = '0;
  logic [N*BW-1:0] m_bytesel = '0;
  logic [N-1:0]    m_io = '0;
  logic [N-1:0]    m_access = '0;
  logic            s_ack = 1'b0;
  logic [DW-1:0]   s_data_in = '0;

  logic [N-1:0]  a_m_ack, b_m_ack;
  logic [DW-1:0] a_m_data_in, b_m_data_in;
  logic [AW-1:0] a_s_addr, b_s_addr;
  logic [DW-1:0] a_s_data_out, b_s_data_out;
  logic          a_s_wr_en, b_s_wr_en;
  logic [BW-1:0] a_s_bytesel, b_s_bytesel;
  logic          a_s_io, b_s_io;
  logic          a_s_access, b_s_access;
  logic [1:0]    a_grant, b_grant;
  logic          a_busy, b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .reset(reset), .m_addr(m_addr), .m_data_out(m_data_out), .m_wr_en(m_wr_en),
    .m_bytesel(m_bytesel), .m_io(m_io), .m_access(m_access), .m_ack(a_m_ack),
    .m_data_in(a_m_data_in), .s_addr(a_s_addr), .s_data_out(a_s_data_out), .s_wr_en(a_s_wr_en),
    .s_bytesel(a_s_bytesel), .s_io(a_s_io), .s_access(a_s_access), .s_ack(s_ack),
    .s_data_in(s_data_in), .grant(a_grant), .busy(a_busy));

  mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .reset(reset), .m_addr(m_addr), .m_data_out(m_data_out), .m_wr_en(m_wr_en),
    .m_bytesel(m_bytesel), .m_io(m_io), .m_access(m_access), .m_ack(b_m_ack),
    .m_data_in(b_m_data_in), .s_addr(b_s_addr), .s_data_out(b_s_data_out), .s_wr_en(b_s_wr_en),
    .s_bytesel(b_s_bytesel), .s_io(b_s_io), .s_access(b_s_access), .s_ack(s_ack),
    .s_data_in(s_data_in), .grant(b_grant), .busy(b_busy));

  typedef struct {
    logic [N-1:0]  acc;
    logic          sack;
    logic [DW-1:0] sdin;
    logic          e_sacc;
    logic [N-1:0]  e_mack;
    logic [1:0]    e_grant;
    logic [AW-1:0] e_saddr;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [AW-1:0] addr_of(input int i);
    return 19'h10000 + AW'(i) * 19'h00111;
  endfunction

  // am = master whose address should be on s_addr, or -1 for the reset value 0
  function automatic vec_t mk(input logic [N-1:0] acc, input logic sack, input logic [DW-1:0] sdin,
                              input logic sacc, input logic [N-1:0] mack, input logic [1:0] g,
                              input int am);
    vec_t v;
    v.acc = acc; v.sack = sack; v.sdin = sdin; v.e_sacc = sacc;
    v.e_mack = mack; v.e_grant = g;
    v.e_saddr = (am < 0) ? '0 : addr_of(am);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_access = '0;
    s_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk(3'b111, 1'b0, 16'h0001, 1'b0, 3'b000, 2'd2, -1);
    vecs[1]  = mk(3'b111, 1'b0, 16'h0002, 1'b1, 3'b000, 2'd0,  0);
    vecs[2]  = mk(3'b111, 1'b1, 16'h0003, 1'b1, 3'b001, 2'd0,  0);
    vecs[3]  = mk(3'b111, 1'b0, 16'h0004, 1'b0, 3'b000, 2'd0,  0);
    vecs[4]  = mk(3'b111, 1'b0, 16'h0005, 1'b1, 3'b000, 2'd1,  1);
    vecs[5]  = mk(3'b111, 1'b1, 16'h0006, 1'b1, 3'b010, 2'd1,  1);
    vecs[6]  = mk(3'b111, 1'b0, 16'h0007, 1'b0, 3'b000, 2'd1,  1);
    vecs[7]  = mk(3'b111, 1'b0, 16'h0008, 1'b1, 3'b000, 2'd2,  2);
    vecs[8]  = mk(3'b111, 1'b1, 16'h0009, 1'b1, 3'b100, 2'd2,  2);
    vecs[9]  = mk(3'b111, 1'b0, 16'h000A, 1'b0, 3'b000, 2'd2,  2);
    vecs[10] = mk(3'b111, 1'b0, 16'h000B, 1'b1, 3'b000, 2'd0,  0);
    vecs[11] = mk(3'b111, 1'b1, 16'h000C, 1'b1, 3'b001, 2'd0,  0);
    vecs[12] = mk(3'b111, 1'b0, 16'h000D, 1'b0, 3'b000, 2'd0,  0);
    vecs[13] = mk(3'b111, 1'b0, 16'h000E, 1'b1, 3'b000, 2'd1,  1);
    vecs[14] = mk(3'b111, 1'b1, 16'h000F, 1'b1, 3'b010, 2'd1,  1);
    vecs[15] = mk(3'b111, 1'b0, 16'h0010, 1'b0, 3'b000, 2'd1,  1);
    vecs[16] = mk(3'b111, 1'b0, 16'h0011, 1'b1, 3'b000, 2'd2,  2);
    vecs[17] = mk(3'b111, 1'b1, 16'h0012, 1'b1, 3'b100, 2'd2,  2);
    vecs[18] = mk(3'b000, 1'b1, 16'h0013, 1'b0, 3'b000, 2'd2,  2);
    vecs[19] = mk(3'b000, 1'b0, 16'h0014, 1'b0, 3'b000, 2'd2,  2);

    do_reset();
    @(negedge clk);
    chk("reset s_access", a_s_access, 1'b0);
    chk("reset busy", a_busy, 1'b0);
    chk("reset grant", a_grant, 2'd2);
    chk("reset s_addr", a_s_addr, 19'h0);
    chk("reset s_wr_en", a_s_wr_en, 1'b0);
    chk("reset m_ack", a_m_ack, 3'b000);
    next_cycle();

    // single write from master 0
    m_addr[0 +: AW] = 19'h12345;
    m_data_out[0 +: DW] = 16'hBEEF;
    m_wr_en = 3'b001;
    m_bytesel = 6'b000011;
    m_io = 3'b000;
    m_access = 3'b001;
    @(negedge clk);
    chk("wr req s_access", a_s_access, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("wr +1 s_access", a_s_access, 1'b1);
    chk("wr +1 s_addr", a_s_addr, 19'h12345);
    chk("wr +1 s_data_out", a_s_data_out, 16'hBEEF);
    chk("wr +1 s_wr_en", a_s_wr_en, 1'b1);
    chk("wr +1 s_bytesel", a_s_bytesel, 2'b11);
    chk("wr +1 grant", a_grant, 2'd0);
    chk("wr +1 m_ack", a_m_ack, 3'b000);
    next_cycle();
    @(negedge clk);
    chk("wr +2 s_access", a_s_access, 1'b1);
    next_cycle();
    s_ack = 1'b1;
    @(negedge clk);
    chk("wr +3 m_ack", a_m_ack, 3'b001);
    next_cycle();
    s_ack = 1'b0;
    m_access = 3'b000;
    @(negedge clk);
    chk("wr +4 s_access", a_s_access, 1'b0);
    chk("wr +4 busy", a_busy, 1'b0);
    chk("wr +4 grant", a_grant, 2'd0);
    next_cycle();

    // read from master 1, with an address change mid-transfer
    m_addr[AW +: AW] = 19'h00ABC;
    m_wr_en = 3'b000;
    m_io = 3'b010;
    m_access = 3'b010;
    next_cycle();
    @(negedge clk);
    chk("rd grant", a_grant, 2'd1);
    chk("rd s_addr", a_s_addr, 19'h00ABC);
    chk("rd s_wr_en", a_s_wr_en, 1'b0);
    chk("rd s_io", a_s_io, 1'b1);
    next_cycle();
    m_addr[AW +: AW] = 19'h7FFFF;
    @(negedge clk);
    chk("rd hold s_addr", a_s_addr, 19'h00ABC);
    next_cycle();
    s_ack = 1'b1;
    s_data_in = 16'hA55A;
    @(negedge clk);
    chk("rd m_data_in", a_m_data_in, 16'hA55A);
    chk("rd m_ack", a_m_ack, 3'b010);
    next_cycle();
    s_ack = 1'b0;
    m_access = 3'b000;

    // master 2 drops its request while busy; the ack still pulses
    m_access = 3'b100;
    next_cycle();
    m_access = 3'b000;
    @(negedge clk);
    chk("drop busy", a_busy, 1'b1);
    chk("drop grant", a_grant, 2'd2);
    next_cycle();
    s_ack = 1'b1;
    @(negedge clk);
    chk("drop m_ack", a_m_ack, 3'b100);
    next_cycle();
    s_ack = 1'b0;
    @(negedge clk);
    chk("drop idle", a_s_access, 1'b0);
    next_cycle();

    // round robin table
    do_reset();
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW] = addr_of(i);
    end
    for (int r = 0; r < 20; r++) begin
      m_access = vecs[r].acc;
      s_ack = vecs[r].sack;
      s_data_in = vecs[r].sdin;
      @(negedge clk);
      chk($sformatf("rr[%0d] s_access", r), a_s_access, vecs[r].e_sacc);
      chk($sformatf("rr[%0d] busy", r), a_busy, vecs[r].e_sacc);
      chk($sformatf("rr[%0d] m_ack", r), a_m_ack, vecs[r].e_mack);
      chk($sformatf("rr[%0d] grant", r), a_grant, vecs[r].e_grant);
      chk($sformatf("rr[%0d] s_addr", r), a_s_addr, vecs[r].e_saddr);
      chk($sformatf("rr[%0d] m_data_in", r), a_m_data_in, vecs[r].sdin);
      next_cycle();
    end
    s_ack = 1'b0;

    // fixed priority: masters 1 and 2 both requesting
    do_reset();
    m_access = 3'b110;
    next_cycle();
    @(negedge clk);
    chk("fp t1 grant", b_grant, 2'd1);
    chk("fp t1 busy", b_busy, 1'b1);
    next_cycle();
    s_ack = 1'b1;
    @(negedge clk);
    chk("fp t1 m_ack", b_m_ack, 3'b010);
    next_cycle();
    s_ack = 1'b0;
    @(negedge clk);
    chk("fp turnaround", b_s_access, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("fp t2 grant", b_grant, 2'd1);
    next_cycle();
    s_ack = 1'b1;
    @(negedge clk);
    chk("fp t2 m_ack", b_m_ack, 3'b010);
    next_cycle();
    s_ack = 1'b0;
    m_access = 3'b100;
    next_cycle();
    @(negedge clk);
    chk("fp t3 grant", b_grant, 2'd2);
    chk("fp t3 busy", b_busy, 1'b1);
    next_cycle();
    s_ack = 1'b1;
    @(negedge clk);
    chk("fp t3 m_ack", b_m_ack, 3'b100);
    next_cycle();
    s_ack = 1'b0;
    m_access = 3'b000;
    next_cycle();

    // reset while busy abandons the transaction
    do_reset();
    m_access = 3'b001;
    next_cycle();
    @(negedge clk);
    chk("rst-busy pre busy", a_busy, 1'b1);
    chk("rst-busy pre grant", a_grant, 2'd0);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    m_access = 3'b000;
    @(negedge clk);
    chk("rst-busy s_access", a_s_access, 1'b0);
    chk("rst-busy busy", a_busy, 1'b0);
    chk("rst-busy grant", a_grant, 2'd2);
    chk("rst-busy s_addr", a_s_addr, 19'h0);
    next_cycle();
    s_ack = 1'b1;
    @(negedge clk);
    chk("rst-busy late ack", a_m_ack, 3'b000);
    next_cycle();
    s_ack = 1'b0;
    @(negedge clk);
    chk("rst-busy stays idle", a_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
